// File: rtl/exec_pkg.sv
// ---------------------------------------------------------------------------
// exec_pkg
//   Shared constants and types for the decode/issue stage that feeds the
//   execute stage (shift ALU, arithmetic/logic ALU, memory stage).
//   Contents:
//     - sizing constants (instruction, register address, immediate widths)
//     - opcode values and per-unit operation codes
//     - instruction field bit positions
//     - decoded_instr_t: every field the stage issues, in one struct
//     - small decode helpers shared by the top level
// ---------------------------------------------------------------------------
package exec_pkg;

    localparam int INSTR_WIDTH     = 32;
    localparam int REG_ADDR_WIDTH  = 5;
    localparam int NUM_REGS        = 2 ** REG_ADDR_WIDTH;
    localparam int IMMEDIATE_WIDTH = 16;
    localparam int OP_WIDTH        = 3;
    localparam int SHIFT_WIDTH     = 5;

    // Opcodes (instr[31:29])
    localparam logic [2:0] SHIFT_REG   = 3'b000;
    localparam logic [2:0] ARITH_LOGIC = 3'b001;
    localparam logic [2:0] MEM_WRITE   = 3'b100;
    localparam logic [2:0] MEM_READ    = 3'b101;

    // Shift ALU operations
    localparam logic [2:0] SHLEFTLOG = 3'b000;
    localparam logic [2:0] SHLEFTART = 3'b001;
    localparam logic [2:0] SHRGHTLOG = 3'b010;
    localparam logic [2:0] SHRGHTART = 3'b011;

    // Arithmetic/logic ALU operations; NOT is the only single-source one
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_NOT = 3'b101;
    localparam logic [2:0] ALU_SLT = 3'b110;
    localparam logic [2:0] ALU_LHG = 3'b111;

    // Load operations (stores issue mem_operation = 0)
    localparam logic [2:0] LOADBYTE = 3'b000;
    localparam logic [2:0] LOADHALF = 3'b001;
    localparam logic [2:0] LOADWORD = 3'b010;

    // Field bit positions
    localparam int OPCODE_MSB    = 31;
    localparam int OPCODE_LSB    = 29;
    localparam int OPERATION_MSB = 28;
    localparam int OPERATION_LSB = 26;
    localparam int DEST_MSB      = 25;
    localparam int DEST_LSB      = 21;
    localparam int SRC1_MSB      = 20;
    localparam int SRC1_LSB      = 16;
    localparam int SRC2_MSB      = 15;
    localparam int SRC2_LSB      = 11;
    localparam int SHIFT_MSB     = 10;
    localparam int SHIFT_LSB     = 6;
    localparam int IMM_MSB       = 15;
    localparam int IMM_LSB       = 0;

    typedef struct packed {
        logic                       enable_shift;
        logic [OP_WIDTH-1:0]        shift_operation;
        logic [SHIFT_WIDTH-1:0]     shift;
        logic                       enable_arith;
        logic [OP_WIDTH-1:0]        alu_operation;
        logic                       enable_mem;
        logic [OP_WIDTH-1:0]        mem_operation;
        logic                       mem_write;
        logic [IMMEDIATE_WIDTH-1:0] immediate;
        logic [REG_ADDR_WIDTH-1:0]  src1;
        logic [REG_ADDR_WIDTH-1:0]  src2;
        logic [REG_ADDR_WIDTH-1:0]  dest;
        logic                       illegal_instr;
    } decoded_instr_t;

    function automatic logic is_legal_opcode(input logic [2:0] opcode);
        return (opcode == SHIFT_REG) || (opcode == ARITH_LOGIC) ||
               (opcode == MEM_WRITE) || (opcode == MEM_READ);
    endfunction

    // src2 is read by two-operand ALU ops and by stores (store data).
    function automatic logic uses_src2(input logic [2:0] opcode,
                                       input logic [2:0] operation);
        return ((opcode == ARITH_LOGIC) && (operation != ALU_NOT)) ||
               (opcode == MEM_WRITE);
    endfunction

    // Opcodes whose result is written back to dest.
    function automatic logic writes_reg(input logic [2:0] opcode);
        return (opcode == SHIFT_REG) || (opcode == ARITH_LOGIC) ||
               (opcode == MEM_READ);
    endfunction

endpackage

// File: rtl/exec_issue_decode_if.sv
// ---------------------------------------------------------------------------
// exec_issue_decode_if
//   Instruction handshake into the decode/issue stage.
//     instr        instruction word (producer -> stage)
//     instr_valid  instr is valid     (producer -> stage)
//     instr_ready  stage accepts      (stage -> producer, combinational)
//   Handshake: a word transfers on a rising clock edge where instr_valid and
//   instr_ready are both 1. instr_ready never depends on anything registered
//   inside the producer, and instr_valid may be asserted without waiting for
//   instr_ready.
//   Modports: master = instruction producer, slave = decode/issue stage.
// ---------------------------------------------------------------------------
interface exec_issue_decode_if #(
    parameter int INSTR_WIDTH = exec_pkg::INSTR_WIDTH
);
    logic [INSTR_WIDTH-1:0] instr;
    logic                   instr_valid;
    logic                   instr_ready;

    modport master (
        output instr,
        output instr_valid,
        input  instr_ready
    );

    modport slave (
        input  instr,
        input  instr_valid,
        output instr_ready
    );
endinterface

// File: rtl/exec_scoreboard.sv
// ---------------------------------------------------------------------------
// exec_scoreboard
//   Register busy vector for RAW hazard detection.
//   Ports:
//     clock, reset        rising-edge clock, async active-low reset
//     set_valid/set_addr  mark a destination busy at the next edge
//     clear_valid/        write-back completes: mark register free
//       clear_addr
//     lookup1_addr/busy   combinational busy query for src1
//     lookup2_addr/busy   combinational busy query for src2
//   Register 0 is never busy. When set and clear hit the same bit on one
//   edge, set wins.
// ---------------------------------------------------------------------------
module exec_scoreboard
    import exec_pkg::*;
#(
    parameter int ADDR_WIDTH = REG_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  set_valid,
    input  logic [ADDR_WIDTH-1:0] set_addr,
    input  logic                  clear_valid,
    input  logic [ADDR_WIDTH-1:0] clear_addr,
    input  logic [ADDR_WIDTH-1:0] lookup1_addr,
    output logic                  lookup1_busy,
    input  logic [ADDR_WIDTH-1:0] lookup2_addr,
    output logic                  lookup2_busy
);
    localparam int ENTRIES = 2 ** ADDR_WIDTH;

    logic [ENTRIES-1:0] busy_q;
    logic [ENTRIES-1:0] busy_d;

    always_comb begin
        busy_d = busy_q;
        if (clear_valid) begin
            busy_d[clear_addr] = 1'b0;
        end
        // Applied after the clear so a simultaneous set of the same bit wins.
        if (set_valid) begin
            busy_d[set_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A write-back landing this cycle already frees its register for the
    // lookup, so the waiting instruction issues on the same edge.
    always_comb begin
        lookup1_busy = busy_q[lookup1_addr] &&
                       !(clear_valid && (clear_addr == lookup1_addr));
        lookup2_busy = busy_q[lookup2_addr] &&
                       !(clear_valid && (clear_addr == lookup2_addr));
    end

endmodule

// File: rtl/exec_issue_decode.sv
// ---------------------------------------------------------------------------
// exec_issue_decode
//   Decode/issue stage producing the registered control inputs of the
//   execute stage. Instructions arrive on a valid/ready handshake, are split
//   into per-unit fields and issued one cycle later with exactly one unit
//   strobe (or illegal_instr). RAW hazards against in-flight destinations
//   hold instr_ready low until write-back clears them.
//   Ports:
//     clock, reset     rising-edge clock, async active-low reset
//     instr_bus        slave side of the instruction handshake
//     exec_stall       downstream freeze: all registered outputs hold
//     wb_valid/wb_dest write-back completion (frees wb_dest)
//     enable_shift, shift_operation, shift           shift ALU controls
//     enable_arith, alu_operation                    arithmetic ALU controls
//     enable_mem, mem_operation, mem_write, immediate memory stage controls
//     src1, src2, dest                               register addresses
//     illegal_instr    one-cycle pulse for an unknown opcode
// ---------------------------------------------------------------------------
module exec_issue_decode
    import exec_pkg::*;
(
    input  logic                       clock,
    input  logic                       reset,
    exec_issue_decode_if.slave         instr_bus,
    input  logic                       exec_stall,
    input  logic                       wb_valid,
    input  logic [REG_ADDR_WIDTH-1:0]  wb_dest,
    output logic                       enable_shift,
    output logic [OP_WIDTH-1:0]        shift_operation,
    output logic [SHIFT_WIDTH-1:0]     shift,
    output logic                       enable_arith,
    output logic [OP_WIDTH-1:0]        alu_operation,
    output logic                       enable_mem,
    output logic [OP_WIDTH-1:0]        mem_operation,
    output logic                       mem_write,
    output logic [IMMEDIATE_WIDTH-1:0] immediate,
    output logic [REG_ADDR_WIDTH-1:0]  src1,
    output logic [REG_ADDR_WIDTH-1:0]  src2,
    output logic [REG_ADDR_WIDTH-1:0]  dest,
    output logic                       illegal_instr
);

    // ---------------- field extraction ----------------
    logic [2:0]                 f_opcode;
    logic [OP_WIDTH-1:0]        f_operation;
    logic [REG_ADDR_WIDTH-1:0]  f_dest;
    logic [REG_ADDR_WIDTH-1:0]  f_src1;
    logic [REG_ADDR_WIDTH-1:0]  f_src2;
    logic [SHIFT_WIDTH-1:0]     f_shift;
    logic [IMMEDIATE_WIDTH-1:0] f_imm;

    assign f_opcode    = instr_bus.instr[OPCODE_MSB:OPCODE_LSB];
    assign f_operation = instr_bus.instr[OPERATION_MSB:OPERATION_LSB];
    assign f_dest      = instr_bus.instr[DEST_MSB:DEST_LSB];
    assign f_src1      = instr_bus.instr[SRC1_MSB:SRC1_LSB];
    assign f_src2      = instr_bus.instr[SRC2_MSB:SRC2_LSB];
    assign f_shift     = instr_bus.instr[SHIFT_MSB:SHIFT_LSB];
    assign f_imm       = instr_bus.instr[IMM_MSB:IMM_LSB];

    // ---------------- hazard / ready ----------------
    logic legal;
    logic src2_used;
    logic src1_busy;
    logic src2_busy;
    logic hazard;
    logic accept;
    logic set_valid;

    always_comb begin
        legal     = is_legal_opcode(f_opcode);
        src2_used = uses_src2(f_opcode, f_operation);
        // Every legal opcode reads src1; illegal opcodes read nothing, so
        // they never wait on the scoreboard.
        hazard    = instr_bus.instr_valid && legal &&
                    (src1_busy || (src2_used && src2_busy));
        instr_bus.instr_ready = !exec_stall && !hazard;
        accept    = instr_bus.instr_valid && instr_bus.instr_ready;
        set_valid = accept && writes_reg(f_opcode) && (f_dest != '0);
    end

    exec_scoreboard #(
        .ADDR_WIDTH (REG_ADDR_WIDTH)
    ) u_scoreboard (
        .clock        (clock),
        .reset        (reset),
        .set_valid    (set_valid),
        .set_addr     (f_dest),
        .clear_valid  (wb_valid),
        .clear_addr   (wb_dest),
        .lookup1_addr (f_src1),
        .lookup1_busy (src1_busy),
        .lookup2_addr (f_src2),
        .lookup2_busy (src2_busy)
    );

    // ---------------- decode ----------------
    decoded_instr_t next_decoded;

    always_comb begin
        next_decoded                 = '0;
        next_decoded.enable_shift    = (f_opcode == SHIFT_REG);
        next_decoded.enable_arith    = (f_opcode == ARITH_LOGIC);
        next_decoded.enable_mem      = (f_opcode == MEM_READ) ||
                                       (f_opcode == MEM_WRITE);
        next_decoded.illegal_instr   = !legal;
        next_decoded.shift_operation = f_operation;
        next_decoded.alu_operation   = f_operation;
        // Stores carry no load width.
        next_decoded.mem_operation   = (f_opcode == MEM_READ) ? f_operation : '0;
        next_decoded.mem_write       = (f_opcode == MEM_WRITE);
        next_decoded.shift           = f_shift;
        next_decoded.immediate       = f_imm;
        next_decoded.src1            = f_src1;
        next_decoded.src2            = f_src2;
        next_decoded.dest            = f_dest;
    end

    // ---------------- output register ----------------
    decoded_instr_t out_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out_q <= '0;
        end else if (!exec_stall) begin
            if (accept) begin
                out_q <= next_decoded;
            end else begin
                // Bubble: strobes drop, fields keep their last issued values.
                out_q.enable_shift  <= 1'b0;
                out_q.enable_arith  <= 1'b0;
                out_q.enable_mem    <= 1'b0;
                out_q.illegal_instr <= 1'b0;
            end
        end
    end

    assign enable_shift    = out_q.enable_shift;
    assign shift_operation = out_q.shift_operation;
    assign shift           = out_q.shift;
    assign enable_arith    = out_q.enable_arith;
    assign alu_operation   = out_q.alu_operation;
    assign enable_mem      = out_q.enable_mem;
    assign mem_operation   = out_q.mem_operation;
    assign mem_write       = out_q.mem_write;
    assign immediate       = out_q.immediate;
    assign src1            = out_q.src1;
    assign src2            = out_q.src2;
    assign dest            = out_q.dest;
    assign illegal_instr   = out_q.illegal_instr;

endmodule

// File: tb/tb_exec_issue_decode.sv
module tb_exec_issue_decode;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       exec_stall = 1'b0;
    logic       wb_valid = 1'b0;
    logic [4:0] wb_dest = '0;
    logic       enable_shift, enable_arith, enable_mem, mem_write, illegal_instr;
    logic [2:0] shift_operation, alu_operation, mem_operation;
    logic [4:0] shift, src1, src2, dest;
    logic [15:0] immediate;

    int total = 0;
    int bad   = 0;

    exec_issue_decode_if ifc ();

    exec_issue_decode dut (
        .clock           (clock),
        .reset           (reset),
        .instr_bus       (ifc.slave),
        .exec_stall      (exec_stall),
        .wb_valid        (wb_valid),
        .wb_dest         (wb_dest),
        .enable_shift    (enable_shift),
        .shift_operation (shift_operation),
        .shift           (shift),
        .enable_arith    (enable_arith),
        .alu_operation   (alu_operation),
        .enable_mem      (enable_mem),
        .mem_operation   (mem_operation),
        .mem_write       (mem_write),
        .immediate       (immediate),
        .src1            (src1),
        .src2            (src2),
        .dest            (dest),
        .illegal_instr   (illegal_instr)
    );

    always #5 clock = ~clock;

    // All outputs in one vector, ordered like exp_t below.
    wire [49:0] dut_out = {enable_shift, shift_operation, shift, enable_arith,
                           alu_operation, enable_mem, mem_operation, mem_write,
                           immediate, src1, src2, dest, illegal_instr};

    // ---------------- reference model ----------------
    typedef struct packed {
        logic       es;
        logic [2:0] so;
        logic [4:0] sh;
        logic       ea;
        logic [2:0] ao;
        logic       em;
        logic [2:0] mo;
        logic       mw;
        logic [15:0] imm;
        logic [4:0] s1;
        logic [4:0] s2;
        logic [4:0] d;
        logic       il;
    } exp_t;

    exp_t m;
    bit   m_busy [32];

    function automatic logic [31:0] enc(input logic [2:0] opc, input logic [2:0] op,
                                        input logic [4:0] d, input logic [4:0] s1,
                                        input logic [4:0] s2, input logic [4:0] sh);
        return {opc, op, d, s1, s2, sh, 6'b0};
    endfunction

    // Registers an instruction reads, straight from the opcode table.
    function automatic void sources_of(input logic [31:0] w, output int srcs[$]);
        int opc = int'(w[31:29]);
        srcs = {};
        case (opc)
            0, 5: srcs.push_back(int'(w[20:16]));
            1: begin
                srcs.push_back(int'(w[20:16]));
                if (w[28:26] != 3'd5) srcs.push_back(int'(w[15:11]));
            end
            4: begin
                srcs.push_back(int'(w[20:16]));
                srcs.push_back(int'(w[15:11]));
            end
            default: ;
        endcase
    endfunction

    function automatic bit model_ready();
        int srcs[$];
        if (exec_stall) return 1'b0;
        if (!ifc.instr_valid) return 1'b1;
        sources_of(ifc.instr, srcs);
        foreach (srcs[i]) begin
            if (srcs[i] != 0 && m_busy[srcs[i]] &&
                !(wb_valid && int'(wb_dest) == srcs[i])) return 1'b0;
        end
        return 1'b1;
    endfunction

    // Advances the model by one clock edge using the current inputs.
    task automatic model_clock();
        logic [31:0] w = ifc.instr;
        int  opc = int'(w[31:29]);
        bit  acc = ifc.instr_valid && model_ready();
        if (!exec_stall) begin
            if (acc) begin
                m.es  = (opc == 0);
                m.ea  = (opc == 1);
                m.em  = (opc == 4) || (opc == 5);
                m.il  = !(opc == 0 || opc == 1 || opc == 4 || opc == 5);
                m.so  = w[28:26];
                m.ao  = w[28:26];
                m.mo  = (opc == 5) ? w[28:26] : 3'd0;
                m.mw  = (opc == 4);
                m.sh  = w[10:6];
                m.imm = w[15:0];
                m.s1  = w[20:16];
                m.s2  = w[15:11];
                m.d   = w[25:21];
            end else begin
                m.es = 0; m.ea = 0; m.em = 0; m.il = 0;
            end
        end
        if (wb_valid) m_busy[wb_dest] = 0;
        if (acc && (opc == 0 || opc == 1 || opc == 5) && w[25:21] != 0)
            m_busy[w[25:21]] = 1;
    endtask

    // ---------------- drivers ----------------
    task automatic idle_inputs();
        ifc.instr_valid = 0;
        exec_stall = 0;
        wb_valid = 0;
        wb_dest = 0;
    endtask

    // Write-back of r, with no instruction offered.
    task automatic free_reg(input logic [4:0] r);
        @(negedge clock);
        idle_inputs();
        wb_valid = 1; wb_dest = r;
        @(negedge clock);
        wb_valid = 0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 0;
        idle_inputs();
        ifc.instr = enc(3'd0, 3'd0, 5'd6, 5'd3, 5'd0, 5'd1);
        repeat (2) @(negedge clock);
        #1;
        total++;
        if (dut_out !== 50'd0) begin
            bad++; $display("FAIL reset_outputs got=%h want=0", dut_out);
        end
        ifc.instr_valid = 1;
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL reset_ready got=%b want=1", ifc.instr_ready);
        end
        @(negedge clock);
        ifc.instr_valid = 0;
        reset = 1;
    endtask

    task automatic test_shift_issue();
        @(negedge clock);
        ifc.instr = 32'h0061_0100;
        ifc.instr_valid = 1;
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL shift_ready got=%b want=1", ifc.instr_ready);
        end
        @(posedge clock); #1;
        total++;
        if ({enable_shift, enable_arith, enable_mem, illegal_instr, shift_operation,
             shift, src1, dest} !== {4'b1000, 3'd0, 5'd4, 5'd1, 5'd3}) begin
            bad++;
            $display("FAIL shift_issue got es=%b ea=%b em=%b il=%b op=%0d sh=%0d s1=%0d d=%0d want 1 0 0 0 0 4 1 3",
                     enable_shift, enable_arith, enable_mem, illegal_instr,
                     shift_operation, shift, src1, dest);
        end
        @(negedge clock);
        ifc.instr_valid = 0;
        @(posedge clock); #1;
        total++;
        if ({enable_shift, shift, dest} !== {1'b0, 5'd4, 5'd3}) begin
            bad++;
            $display("FAIL shift_bubble got es=%b sh=%0d d=%0d want es=0 sh=4 d=3",
                     enable_shift, shift, dest);
        end
    endtask

    task automatic test_raw_stall();
        @(negedge clock);
        ifc.instr = 32'h20A3_1000;
        ifc.instr_valid = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ifc.instr_ready !== 1'b0) begin
                bad++; $display("FAIL raw_hold_ready[%0d] got=%b want=0", i, ifc.instr_ready);
            end
            @(posedge clock); #1;
            total++;
            if (enable_arith !== 1'b0) begin
                bad++; $display("FAIL raw_hold_strobe[%0d] got=%b want=0", i, enable_arith);
            end
            @(negedge clock);
        end
        wb_valid = 1; wb_dest = 5'd3;
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL raw_release_ready got=%b want=1", ifc.instr_ready);
        end
        @(posedge clock); #1;
        total++;
        if ({enable_arith, enable_shift, alu_operation, dest, src1, src2} !==
            {2'b10, 3'd0, 5'd5, 5'd3, 5'd2}) begin
            bad++;
            $display("FAIL raw_issue got ea=%b es=%b op=%0d d=%0d s1=%0d s2=%0d want 1 0 0 5 3 2",
                     enable_arith, enable_shift, alu_operation, dest, src1, src2);
        end
        @(negedge clock);
        idle_inputs();
        // r5 now busy, r3 free
        ifc.instr = enc(3'd0, 3'd0, 5'd6, 5'd5, 5'd0, 5'd1);
        ifc.instr_valid = 1;
        #1;
        total++;
        if (ifc.instr_ready !== 1'b0) begin
            bad++; $display("FAIL raw_r5_busy got=%b want=0", ifc.instr_ready);
        end
        ifc.instr = enc(3'd0, 3'd0, 5'd6, 5'd3, 5'd0, 5'd1);
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL raw_r3_free got=%b want=1", ifc.instr_ready);
        end
        ifc.instr_valid = 0;
        free_reg(5'd5);
    endtask

    task automatic test_store();
        @(negedge clock);
        ifc.instr = 32'h8022_1234;
        ifc.instr_valid = 1;
        @(posedge clock); #1;
        total++;
        if ({enable_mem, mem_write, mem_operation, immediate, src1, src2, dest,
             enable_shift, enable_arith} !==
            {2'b11, 3'd0, 16'h1234, 5'd2, 5'd2, 5'd1, 2'b00}) begin
            bad++;
            $display("FAIL store_issue got em=%b mw=%b mo=%0d imm=%h s1=%0d s2=%0d d=%0d want 1 1 0 1234 2 2 1",
                     enable_mem, mem_write, mem_operation, immediate, src1, src2, dest);
        end
        @(negedge clock);
        ifc.instr = enc(3'd0, 3'd0, 5'd6, 5'd1, 5'd0, 5'd1);
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL store_no_busy got=%b want=1", ifc.instr_ready);
        end
        ifc.instr_valid = 0;
    endtask

    task automatic test_stall();
        @(negedge clock);
        ifc.instr = enc(3'd1, 3'd1, 5'd7, 5'd1, 5'd2, 5'd0);
        ifc.instr_valid = 1;
        @(negedge clock);
        exec_stall = 1;
        ifc.instr = enc(3'd0, 3'd2, 5'd9, 5'd4, 5'd0, 5'd3);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++;
            if (ifc.instr_ready !== 1'b0) begin
                bad++; $display("FAIL stall_ready[%0d] got=%b want=0", i, ifc.instr_ready);
            end
            @(posedge clock); #1;
            total++;
            if ({enable_arith, enable_shift, alu_operation, dest, src1, src2} !==
                {2'b10, 3'd1, 5'd7, 5'd1, 5'd2}) begin
                bad++;
                $display("FAIL stall_hold[%0d] got ea=%b es=%b op=%0d d=%0d want 1 0 1 7",
                         i, enable_arith, enable_shift, alu_operation, dest);
            end
            @(negedge clock);
        end
        idle_inputs();
        @(posedge clock); #1;
        total++;
        if ({enable_arith, enable_shift, dest} !== {2'b00, 5'd7}) begin
            bad++; $display("FAIL stall_release got ea=%b es=%b d=%0d want 0 0 7",
                            enable_arith, enable_shift, dest);
        end
        free_reg(5'd7);
    endtask

    task automatic test_illegal();
        @(negedge clock);
        ifc.instr = enc(3'd0, 3'd0, 5'd4, 5'd1, 5'd0, 5'd1);
        ifc.instr_valid = 1;
        @(negedge clock);
        // Fields point at busy r4, but an illegal opcode has no sources.
        ifc.instr = 32'hE000_0000 | enc(3'd0, 3'd0, 5'd6, 5'd4, 5'd4, 5'd0);
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL illegal_ready got=%b want=1", ifc.instr_ready);
        end
        @(posedge clock); #1;
        total++;
        if ({illegal_instr, enable_shift, enable_arith, enable_mem} !== 4'b1000) begin
            bad++; $display("FAIL illegal_pulse got il/es/ea/em=%b want 1000",
                            {illegal_instr, enable_shift, enable_arith, enable_mem});
        end
        @(negedge clock);
        ifc.instr = enc(3'd0, 3'd0, 5'd1, 5'd6, 5'd0, 5'd1);
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL illegal_no_set got=%b want=1", ifc.instr_ready);
        end
        ifc.instr = enc(3'd0, 3'd0, 5'd1, 5'd4, 5'd0, 5'd1);
        #1;
        total++;
        if (ifc.instr_ready !== 1'b0) begin
            bad++; $display("FAIL illegal_keeps_r4 got=%b want=0", ifc.instr_ready);
        end
        ifc.instr_valid = 0;
        @(posedge clock); #1;
        total++;
        if (illegal_instr !== 1'b0) begin
            bad++; $display("FAIL illegal_one_cycle got=%b want=0", illegal_instr);
        end
        free_reg(5'd4);
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        ifc.instr = 32'h0061_0100;
        ifc.instr_valid = 1;
        @(posedge clock); #1;
        ifc.instr_valid = 0;
        exec_stall = 1;
        total++;
        if (enable_shift !== 1'b1) begin
            bad++; $display("FAIL areset_pre got=%b want=1", enable_shift);
        end
        #1 reset = 0;
        #1;
        total++;
        if (dut_out !== 50'd0) begin
            bad++; $display("FAIL areset_outputs got=%h want=0", dut_out);
        end
        @(negedge clock);
        reset = 1;
        exec_stall = 0;
        ifc.instr = enc(3'd0, 3'd0, 5'd6, 5'd3, 5'd0, 5'd1);
        ifc.instr_valid = 1;
        #1;
        total++;
        if (ifc.instr_ready !== 1'b1) begin
            bad++; $display("FAIL areset_r3_free got=%b want=1", ifc.instr_ready);
        end
        ifc.instr_valid = 0;
    endtask

    task automatic test_random();
        int pick;
        logic [2:0] opc;
        logic [2:0] illegal_codes [4] = '{3'd2, 3'd3, 3'd6, 3'd7};
        @(negedge clock);
        idle_inputs();
        reset = 0;
        @(negedge clock);
        reset = 1;
        m = '0;
        foreach (m_busy[i]) m_busy[i] = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clock);
            pick = $urandom_range(0, 9);
            if (pick <= 2) opc = 3'd0;
            else if (pick <= 5) opc = 3'd1;
            else if (pick <= 7) opc = 3'd5;
            else if (pick == 8) opc = 3'd4;
            else opc = illegal_codes[$urandom_range(0, 3)];
            ifc.instr = {opc, 3'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                         5'($urandom_range(0, 31)), 6'($urandom_range(0, 63))};
            ifc.instr_valid = ($urandom_range(0, 3) != 0);
            exec_stall = ($urandom_range(0, 6) == 0);
            wb_valid = ($urandom_range(0, 9) < 4);
            wb_dest = 5'($urandom_range(0, 7));
            #1;
            total++;
            if (ifc.instr_ready !== model_ready()) begin
                bad++; $display("FAIL rand_ready cyc=%0d got=%b want=%b",
                                cyc, ifc.instr_ready, model_ready());
            end
            model_clock();
            @(posedge clock); #1;
            total++;
            if (dut_out !== m) begin
                bad++; $display("FAIL rand_outputs cyc=%0d got=%h want=%h",
                                cyc, dut_out, m);
            end
        end
        @(negedge clock);
        idle_inputs();
    endtask

    initial begin
        ifc.instr = '0;
        ifc.instr_valid = 0;
        test_reset();
        test_shift_issue();
        test_raw_stall();
        test_store();
        test_stall();
        test_illegal();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
